// File: rtl/fadd_issue_arbiter_if.sv
// Requester-side bundle for fadd_issue_arbiter: issue handshake plus the
// registered result pulse returned to the owning requester.
interface fadd_issue_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [31:0]           resp_data;

  modport master (output req_valid, req_a, req_b, req_op,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_a, req_b, req_op,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fadd_issue_arbiter.sv
// Round-robin issue arbiter for one shared fixed-latency FP adder, with a tag
// pipeline that routes each result back to its owner and per-requester credits.

module fadd_issue_credit #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic issue,
  input  logic retire,
  output logic elig
);
  logic [CW-1:0] cnt;

  // Compared before the edge, so a retire frees the credit for the next cycle.
  assign elig = valid && (cnt < CW'(MAX_OUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (issue && !retire) cnt <= cnt + CW'(1);
    else if (retire && !issue) cnt <= cnt - CW'(1);
  end
endmodule

module fadd_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int LAT     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fadd_issue_arbiter_if.slave  rq,
  output logic [31:0]          fadd_a,
  output logic [31:0]          fadd_b,
  output logic                 fadd_op,
  input  logic [31:0]          fadd_result,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [NREQ-1:0] valid;
    logic [31:0]     data;
  } resp_t;

  logic [IW-1:0]           ptr;
  logic [NREQ-1:0]         elig;
  logic [NREQ-1:0]         gnt;
  logic                    gnt_any;
  logic [IW-1:0]           gnt_id;
  logic [LAT-1:0]          vld_pipe;
  logic [LAT-1:0][IW-1:0]  id_pipe;
  logic                    retire;
  logic [IW-1:0]           ret_id;
  logic [NREQ-1:0]         ret_vec;
  resp_t                   resp_q;

  assign retire  = vld_pipe[LAT-1];
  assign ret_id  = id_pipe[LAT-1];
  assign ret_vec = retire ? (NREQ'(1) << ret_id) : '0;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    fadd_issue_credit #(.MAX_OUT(MAX_OUT), .CW(CW)) u_cred (
      .clk    (clk),
      .rst    (rst),
      .valid  (rq.req_valid[g]),
      .issue  (gnt[g]),
      .retire (ret_vec[g]),
      .elig   (elig[g])
    );
  end

  // Search starts one past the last winner; skipped requesters keep their turn.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_any && elig[IW'((int'(ptr) + k) % NREQ)]) begin
        gnt_id  = IW'((int'(ptr) + k) % NREQ);
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign rq.req_ready = gnt;
  assign fadd_a       = gnt_any ? rq.req_a[gnt_id]  : '0;
  assign fadd_b       = gnt_any ? rq.req_b[gnt_id]  : '0;
  assign fadd_op      = gnt_any ? rq.req_op[gnt_id] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= IW'(NREQ - 1);
    else if (gnt_any) ptr <= gnt_id;
  end

  // Tag travels beside the adder pipeline; stage LAT-1 lines up with fadd_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= gnt_any;
      id_pipe[0]  <= gnt_id;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
    end else if (retire) begin
      resp_q.valid <= ret_vec;
      resp_q.data  <= fadd_result;
    end else begin
      resp_q.valid <= '0;
    end
  end

  assign rq.resp_valid = resp_q.valid;
  assign rq.resp_data  = resp_q.data;
  assign busy          = (|vld_pipe) | (|resp_q.valid);
endmodule
